// File: rtl/alu_pkg.sv
// ALU op codes and sequencer state encoding shared by the ALU, the sequencer and benches.
// No logic; constants and types only.
// Op code values match the ALU decoder; unknown codes are passed through untouched.
package alu_pkg;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SRA = 6'b000011;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_NOR = 6'b100111;

    // Flag states are only reachable when ALU_IF_FLAGS_EN is defined
    typedef enum logic [2:0] {
        ST_WAIT_A      = 3'd0,
        ST_WAIT_B      = 3'd1,
        ST_WAIT_OP     = 3'd2,
        ST_EXEC        = 3'd3,
        ST_SEND_RES    = 3'd4,
        ST_WAIT_TX     = 3'd5,
        ST_SEND_FLG    = 3'd6,
        ST_WAIT_TX_FLG = 3'd7
    } alu_if_state_t;

endpackage

// File: rtl/alu_uart_interface.sv
// Sequencer: three UART bytes (A, B, op) into the ALU, result (and optionally flags) back to UART tx.
// Latency: op byte i_rx_done in cycle N -> o_tx_start pulse in cycle N+2.
// Backpressure: rx bytes arriving while busy are dropped; each tx byte waits for i_tx_done.
// Optional macro ALU_IF_FLAGS_EN: send a second byte {0.., carry, zero} after the result.
module alu_uart_interface
    import alu_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    input  logic                  i_tx_done,
    output logic [NB_DATA-1:0]    o_data_a,
    output logic [NB_DATA-1:0]    o_data_b,
    output logic [NB_OP_CODE-1:0] o_op_code,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy
);

    alu_if_state_t          state_q, state_d;
    logic [NB_DATA-1:0]     data_a_q;
    logic [NB_DATA-1:0]     data_b_q;
    logic [NB_OP_CODE-1:0]  op_code_q;
    logic [NB_DATA-1:0]     tx_data_q;
    logic                   tx_start_q;

`ifdef ALU_IF_FLAGS_EN
    logic                   carry_q;
    logic                   zero_q;
`else
    // Flag inputs have no consumer in the result-only build
    logic                   unused_flags;
    assign unused_flags = ^{i_alu_carry, i_alu_zero};
`endif

    // Next-state logic: byte collection, execute, then one handshake per transmitted byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A:   if (i_rx_done) state_d = ST_WAIT_B;
            ST_WAIT_B:   if (i_rx_done) state_d = ST_WAIT_OP;
            ST_WAIT_OP:  if (i_rx_done) state_d = ST_EXEC;
            ST_EXEC:     state_d = ST_SEND_RES;
            // tx_done coinciding with the start pulse belongs to no byte of ours
            ST_SEND_RES: state_d = ST_WAIT_TX;
`ifdef ALU_IF_FLAGS_EN
            ST_WAIT_TX:     if (i_tx_done) state_d = ST_SEND_FLG;
            ST_SEND_FLG:    state_d = ST_WAIT_TX_FLG;
            ST_WAIT_TX_FLG: if (i_tx_done) state_d = ST_WAIT_A;
`else
            ST_WAIT_TX:  if (i_tx_done) state_d = ST_WAIT_A;
`endif
            default:     state_d = ST_WAIT_A;
        endcase
    end

    // State register; reset aborts any command including one mid-transmit
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, result/flag capture and tx byte/start generation
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_code_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef ALU_IF_FLAGS_EN
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_WAIT_A:  if (i_rx_done) data_a_q  <= i_rx_data;
                ST_WAIT_B:  if (i_rx_done) data_b_q  <= i_rx_data;
                ST_WAIT_OP: if (i_rx_done) op_code_q <= i_rx_data[NB_OP_CODE-1:0];
                // Operands have been stable for a full cycle; load the tx byte so it is
                // already valid in the cycle the start pulse is seen
                ST_EXEC: begin
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
`ifdef ALU_IF_FLAGS_EN
                    carry_q    <= i_alu_carry;
                    zero_q     <= i_alu_zero;
`endif
                end
`ifdef ALU_IF_FLAGS_EN
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        tx_data_q  <= {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
                        tx_start_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op_code  = op_code_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = !(state_q inside {ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP});

endmodule
